// File: rtl/lrelu_pipe.sv
// Activation stage (bypass / ReLU / leaky / clamped ReLU): 2-stage pipeline, 2-cycle latency, 1 beat/cycle.
// Skid-free valid/ready: in_ready drops only when S1 and S2 are both full and blocked; stall freezes all state.
module lrelu_pipe #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              cfg_mode,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic [DATA_W-1:0]       cfg_clamp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        neg_cnt,
    input  logic                    cnt_clr
);
    localparam int NEG_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [1:0]         mode;
        logic [SHIFT_W-1:0] shift;
        logic [DATA_W-1:0]  clamp;
    } cfg_t;

    logic                    s1_v, s2_v, s1_adv, s2_adv, in_hs;
    logic [LANES*DATA_W-1:0] s1_data, s2_data, act_data;
    cfg_t                    s1_cfg, in_cfg;
    logic [NEG_W-1:0]        in_negs;
    logic [CNT_W:0]          cnt_sum;

    function automatic logic [DATA_W-1:0] act_lane(input logic signed [DATA_W-1:0] x,
                                                    input cfg_t c);
        logic signed [DATA_W-1:0] clamp;
        logic [DATA_W-1:0]        r;
        clamp = $signed(c.clamp);
        r     = x;
        case (c.mode)
            2'b01: if (x[DATA_W-1]) r = '0;
            2'b10: if (x[DATA_W-1]) r = x >>> c.shift;
            2'b11: begin
                // A negative clamp forces zero even for non-negative x
                if (x[DATA_W-1] || clamp[DATA_W-1]) r = '0;
                else if (x > clamp)                 r = clamp;
            end
            default: r = x;
        endcase
        return r;
    endfunction

    assign in_cfg    = {cfg_mode, cfg_shift, cfg_clamp};
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = s1_v && s2_adv;
    assign in_ready  = !stall && (!s1_v || s2_adv);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = s2_v && !stall;
    assign out_data  = s2_data;

    always_comb begin
        act_data = '0;
        for (int i = 0; i < LANES; i++)
            act_data[i*DATA_W +: DATA_W] = act_lane(s1_data[i*DATA_W +: DATA_W], s1_cfg);
    end

    always_comb begin
        in_negs = '0;
        for (int i = 0; i < LANES; i++)
            in_negs = in_negs + NEG_W'(in_data[i*DATA_W + DATA_W - 1]);
    end

    assign cnt_sum = {1'b0, neg_cnt} + {{(CNT_W + 1 - NEG_W){1'b0}}, in_negs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_cfg  <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_cfg  <= in_cfg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
        end else if (!stall && s2_adv) begin
            s2_v <= s1_v;
            if (s1_adv) s2_data <= act_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_cnt <= '0;
        end else if (!stall) begin
            if (cnt_clr)    neg_cnt <= '0;
            else if (in_hs) neg_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_lrelu_pipe.sv
// Scoreboard bench for lrelu_pipe: randomized beats checked against an integer-arithmetic reference model.
module tb_lrelu_pipe;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int SW     = 3;
    localparam int CW     = 16;
    localparam int CMAX   = 65535;

    logic                    clk, rst, stall, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [LANES*DATA_W-1:0] in_data, out_data;
    logic [1:0]              cfg_mode;
    logic [SW-1:0]           cfg_shift;
    logic [DATA_W-1:0]       cfg_clamp;
    logic [CW-1:0]           neg_cnt;

    int tests = 0, fails = 0, cyc = 0, model_cnt = 0, bp_mode = 0, acc_c;
    bit lat_chk = 0, prev_hold = 0;
    logic [63:0] exp_q[$];
    int          acc_q[$];

    lrelu_pipe #(.DATA_W(DATA_W), .LANES(LANES), .SHIFT_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_clamp(cfg_clamp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .neg_cnt(neg_cnt), .cnt_clr(cnt_clr));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // 0: always ready, 1: random, 2: never ready
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_lane(input int x, input int mode, input int sh, input int clamp);
        int r, d;
        case (mode)
            0: r = x;
            1: r = (x < 0) ? 0 : x;
            2: begin
                d = 1 << sh;
                r = x;
                if (x < 0) begin
                    r = x / d;                       // truncates toward zero
                    if (x % d != 0) r = r - 1;       // so step down for floor
                end
            end
            default: begin
                if (x < 0 || clamp < 0) r = 0;
                else if (x > clamp)     r = clamp;
                else                    r = x;
            end
        endcase
        return 16'(r);
    endfunction

    function automatic logic [63:0] model_beat(input logic [63:0] d, input logic [1:0] m,
                                               input logic [2:0] s, input logic [15:0] c);
        logic [63:0]        r;
        logic signed [15:0] l, cs;
        cs = c;
        r  = '0;
        for (int i = 0; i < LANES; i++) begin
            l = d[i*16 +: 16];
            r[i*16 +: 16] = model_lane(int'(l), int'(m), int'(s), int'(cs));
        end
        return r;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [1:0] m, input logic [2:0] s,
                             input logic [15:0] c, input bit first_try);
        int waited = 0;
        int negs   = 0;
        in_valid = 1'b1; in_data = d; cfg_mode = m; cfg_shift = s; cfg_clamp = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 2000) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (first_try) chk("in_ready_bubble", 64'(waited), 64'd0);
        exp_q.push_back(model_beat(d, m, s, c));
        acc_q.push_back(cyc);
        for (int i = 0; i < LANES; i++) if (d[i*16 + 15]) negs++;
        model_cnt = cnt_clr ? 0 : ((model_cnt + negs > CMAX) ? CMAX : model_cnt + negs);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; stall = 1'b0;
        exp_q.delete(); acc_q.delete(); model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) prev_hold = 0;
        else begin
            if (prev_hold && !stall) chk("valid_dropped", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
                else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_c = acc_q.pop_front();
                        if (lat_chk) chk("latency", 64'(cyc - acc_c), 64'd2);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sweep, edge_d, d;
        sweep  = {16'h7FFF, 16'h8000, 16'h0007, 16'hFFFB};
        edge_d = {16'hFFFE, 16'h0064, 16'hFFFB, 16'hFFFF};

        // Reset with garbage on the inputs
        rst = 1'b1; stall = 1'b0; cnt_clr = 1'b0; bp_mode = 1;
        in_valid = 1'b1; in_data = {$urandom, $urandom};
        cfg_mode = 2'b10; cfg_shift = 3'd5; cfg_clamp = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_neg_cnt", 64'(neg_cnt), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0; bp_mode = 0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Mode sweep plus shift/clamp corner cases
        send_beat(sweep, 2'b00, 3'd0, 16'd0, 1'b0);
        send_beat(sweep, 2'b01, 3'd0, 16'd0, 1'b0);
        send_beat(sweep, 2'b10, 3'd2, 16'd0, 1'b0);
        send_beat(sweep, 2'b11, 3'd0, 16'd6, 1'b0);
        chk("sweep_neg_cnt", 64'(neg_cnt), 64'd8);
        send_beat(sweep,  2'b11, 3'd0, 16'hFFFD, 1'b0);
        send_beat(edge_d, 2'b10, 3'd0, 16'd0, 1'b0);
        send_beat(edge_d, 2'b10, 3'd7, 16'd0, 1'b0);
        send_beat(edge_d, 2'b11, 3'd0, 16'd80, 1'b0);
        drain();
        chk("sweep_cnt_model", 64'(neg_cnt), 64'(model_cnt));

        // Back-to-back streaming: latency 2, no bubbles
        do_reset();
        lat_chk = 1;
        for (int i = 0; i < 100; i++)
            send_beat({$urandom, $urandom}, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      16'($urandom), 1'b1);
        drain();
        lat_chk = 0;

        // Random backpressure and random input gaps
        bp_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_beat({$urandom, $urandom}, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      16'($urandom), 1'b0);
        end
        drain();
        bp_mode = 0;
        chk("random_cnt_model", 64'(neg_cnt), 64'(model_cnt));

        // Fill S1/S2 under backpressure, then stall with out_ready high
        do_reset();
        bp_mode = 2;
        @(posedge clk); #1;
        send_beat(sweep,  2'b01, 3'd0, 16'd0, 1'b0);
        send_beat(edge_d, 2'b10, 3'd1, 16'd0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        stall = 1'b1; bp_mode = 0;
        in_valid = 1'b1; in_data = 64'h8000_8000_8000_8000; cfg_mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_data", out_data, exp_q[0]);
            chk("stall_neg_cnt", 64'(neg_cnt), 64'(model_cnt));
            @(posedge clk); #1;
        end
        stall = 1'b0; in_valid = 1'b0;
        drain();

        // Reset with beats in flight discards them
        bp_mode = 2;
        @(posedge clk); #1;
        send_beat(sweep, 2'b00, 3'd0, 16'd0, 1'b0);
        send_beat(sweep, 2'b01, 3'd0, 16'd0, 1'b0);
        do_reset();
        bp_mode = 0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
            chk("midrst_out_data", out_data, 64'd0);
        end
        @(posedge clk); #1;
        send_beat(edge_d, 2'b01, 3'd0, 16'd0, 1'b0);
        drain();

        // Counter saturation and clear priority
        do_reset();
        for (int i = 0; i < 16383; i++) begin
            d = {16'h8000 | 16'($urandom), 16'h8000 | 16'($urandom),
                 16'h8000 | 16'($urandom), 16'h8000 | 16'($urandom)};
            send_beat(d, 2'b00, 3'd0, 16'd0, 1'b0);
        end
        send_beat(sweep, 2'b00, 3'd0, 16'd0, 1'b0);
        chk("cnt_preload", 64'(neg_cnt), 64'd65534);
        send_beat(64'hFFFF_8000_9000_A000, 2'b00, 3'd0, 16'd0, 1'b0);
        chk("cnt_saturate", 64'(neg_cnt), 64'd65535);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 3'd0, 16'd0, 1'b0);
        chk("cnt_hold_max", 64'(neg_cnt), 64'd65535);
        cnt_clr = 1'b1;
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 3'd0, 16'd0, 1'b0);
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", 64'(neg_cnt), 64'd0);
        chk("cnt_model", 64'(neg_cnt), 64'(model_cnt));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
